// File: rtl/seq_control_unit_pkg.sv
// Shared opcode, ALU-select, control-bundle and state encodings for seq_control_unit.
package seq_control_unit_pkg;

  localparam int unsigned CntW = 3;

  // Opcodes; anything from 24 upwards is undefined.
  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_SETC = 1;
  localparam int unsigned OP_CLRC = 2;
  localparam int unsigned OP_NOT  = 3;
  localparam int unsigned OP_INC  = 4;
  localparam int unsigned OP_DEC  = 5;
  localparam int unsigned OP_MOV  = 6;
  localparam int unsigned OP_ADD  = 7;
  localparam int unsigned OP_SUB  = 8;
  localparam int unsigned OP_AND  = 9;
  localparam int unsigned OP_OR   = 10;
  localparam int unsigned OP_IN   = 11;
  localparam int unsigned OP_OUT  = 12;
  localparam int unsigned OP_PUSH = 13;
  localparam int unsigned OP_POP  = 14;
  localparam int unsigned OP_LDM  = 15;
  localparam int unsigned OP_LDD  = 16;
  localparam int unsigned OP_STD  = 17;
  localparam int unsigned OP_JZ   = 18;
  localparam int unsigned OP_JMP  = 19;
  localparam int unsigned OP_CALL = 20;
  localparam int unsigned OP_RET  = 21;
  localparam int unsigned OP_RTI  = 22;
  localparam int unsigned OP_INT  = 23;

  localparam int unsigned ALU_NOP = 0;
  localparam int unsigned ALU_ADD = 1;
  localparam int unsigned ALU_SUB = 2;
  localparam int unsigned ALU_AND = 3;
  localparam int unsigned ALU_OR  = 4;
  localparam int unsigned ALU_NOT = 5;
  localparam int unsigned ALU_INC = 6;
  localparam int unsigned ALU_DEC = 7;
  localparam int unsigned ALU_MOV = 8;

  // Bundle bit order: {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
  localparam logic [9:0] CTRL_NOP       = 10'b0000000000;
  localparam logic [9:0] ALU_SIGNALS    = 10'b0000001000;
  localparam logic [9:0] BRANCH_SIGNALS = 10'b0000000100;
  localparam logic [9:0] CTRL_LDM_IMM   = 10'b0000011000;
  localparam logic [9:0] CTRL_INT       = 10'b0001000100;
  localparam logic [9:0] CTRL_PUSH      = 10'b0001000000;
  localparam logic [9:0] CTRL_SETC      = 10'b0000000010;
  localparam logic [9:0] CTRL_CLRC      = 10'b0000000001;
  localparam logic [9:0] CTRL_IN        = 10'b1000001000;
  localparam logic [9:0] CTRL_OUT       = 10'b0100000000;
  localparam logic [9:0] CTRL_POP       = 10'b0010101000;
  localparam logic [9:0] CTRL_LDD       = 10'b0010111000;
  localparam logic [9:0] CTRL_STD       = 10'b0001010000;
  localparam logic [9:0] CTRL_CALL      = 10'b0001000100;

  typedef enum logic [1:0] {
    CU_ST_DECODE  = 2'd0,
    CU_ST_LDM_IMM = 2'd1,
    CU_ST_FLUSH   = 2'd2,
    CU_ST_INT_SEQ = 2'd3
  } cu_state_e;

  typedef enum logic [2:0] {
    KindNormal = 3'd0,
    KindLdm    = 3'd1,
    KindRet    = 3'd2,
    KindRti    = 3'd3,
    KindInt    = 3'd4
  } cu_kind_e;

endpackage

// File: rtl/cu_decode_rom.sv
// Combinational opcode -> {control bundle, ALU select, illegal flag, sequencing kind}.
module cu_decode_rom
  import seq_control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_W  = 5,
  parameter int unsigned ALU_SEL_W = 4
) (
  input  logic [OPCODE_W-1:0]  opcode_i,
  output logic [9:0]           ctrl_o,
  output logic [ALU_SEL_W-1:0] alu_sel_o,
  output logic                 illegal_o,
  output cu_kind_e             kind_o
);

  always_comb begin
    ctrl_o    = CTRL_NOP;
    alu_sel_o = ALU_SEL_W'(ALU_NOP);
    illegal_o = 1'b0;
    kind_o    = KindNormal;
    case (32'(opcode_i))
      OP_NOP:  ctrl_o = CTRL_NOP;
      OP_SETC: ctrl_o = CTRL_SETC;
      OP_CLRC: ctrl_o = CTRL_CLRC;
      OP_NOT:  begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_NOT); end
      OP_INC:  begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_INC); end
      OP_DEC:  begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_DEC); end
      OP_MOV:  begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_MOV); end
      OP_ADD:  begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_ADD); end
      OP_SUB:  begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_SUB); end
      OP_AND:  begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_AND); end
      OP_OR:   begin ctrl_o = ALU_SIGNALS; alu_sel_o = ALU_SEL_W'(ALU_OR);  end
      OP_IN:   begin ctrl_o = CTRL_IN;     alu_sel_o = ALU_SEL_W'(ALU_MOV); end
      OP_OUT:  ctrl_o = CTRL_OUT;
      OP_PUSH: ctrl_o = CTRL_PUSH;
      OP_POP:  ctrl_o = CTRL_POP;
      OP_LDM:  kind_o = KindLdm;
      OP_LDD:  begin ctrl_o = CTRL_LDD;    alu_sel_o = ALU_SEL_W'(ALU_ADD); end
      OP_STD:  begin ctrl_o = CTRL_STD;    alu_sel_o = ALU_SEL_W'(ALU_ADD); end
      OP_JZ:   ctrl_o = BRANCH_SIGNALS;
      OP_JMP:  ctrl_o = BRANCH_SIGNALS;
      OP_CALL: ctrl_o = CTRL_CALL;
      OP_RET:  begin ctrl_o = BRANCH_SIGNALS; kind_o = KindRet; end
      OP_RTI:  begin ctrl_o = BRANCH_SIGNALS; kind_o = KindRti; end
      OP_INT:  begin ctrl_o = CTRL_INT;       kind_o = KindInt; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// Registered decode/sequencing stage between IF/ID and ID/EX.
// Optional CU_PERF_CNT_EN adds saturating bubble and instruction counters.
module seq_control_unit
  import seq_control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 5,
  parameter int unsigned ALU_SEL_W   = 4,
  parameter int unsigned RET_BUBBLES = 2,
  parameter int unsigned RTI_BUBBLES = 3,
  parameter int unsigned INT_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_vld_i,
  input  logic [OPCODE_W-1:0]  opcode_i,
  input  logic                 stall_i,
  input  logic                 kill_i,
  output logic [9:0]           ctrl_o,
  output logic [ALU_SEL_W-1:0] alu_sel_o,
  output logic                 imm_o,
  output logic                 pc_hold_o,
  output logic                 ctrl_vld_o,
  output logic                 busy_o,
  output logic                 illegal_o
`ifdef CU_PERF_CNT_EN
  ,
  output logic [15:0]          bubble_cnt_o,
  output logic [15:0]          instr_cnt_o
`endif
);

  if (RET_BUBBLES < 1 || RET_BUBBLES > 7) begin : gen_bad_ret
    $error("RET_BUBBLES must be 1..7");
  end
  if (RTI_BUBBLES < 1 || RTI_BUBBLES > 7) begin : gen_bad_rti
    $error("RTI_BUBBLES must be 1..7");
  end
  if (INT_CYCLES < 1 || INT_CYCLES > 7) begin : gen_bad_int
    $error("INT_CYCLES must be 1..7");
  end
  if (OPCODE_W < 5 || ALU_SEL_W < 4) begin : gen_bad_width
    $error("OPCODE_W must be >= 5 and ALU_SEL_W >= 4");
  end

  logic [9:0]           rom_ctrl;
  logic [ALU_SEL_W-1:0] rom_alu_sel;
  logic                 rom_illegal;
  cu_kind_e             rom_kind;

  cu_decode_rom #(
    .OPCODE_W  (OPCODE_W),
    .ALU_SEL_W (ALU_SEL_W)
  ) u_rom (
    .opcode_i  (opcode_i),
    .ctrl_o    (rom_ctrl),
    .alu_sel_o (rom_alu_sel),
    .illegal_o (rom_illegal),
    .kind_o    (rom_kind)
  );

  cu_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [9:0]           ctrl_q, ctrl_d;
  logic [ALU_SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic                 imm_q, imm_d;
  logic                 pc_hold_q, pc_hold_d;
  logic                 vld_q, vld_d;
  logic                 illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = CTRL_NOP;
    alu_sel_d = ALU_SEL_W'(ALU_NOP);
    imm_d     = 1'b0;
    pc_hold_d = 1'b0;
    vld_d     = 1'b0;
    illegal_d = 1'b0;
    if (kill_i) begin
      state_d = CU_ST_DECODE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CU_ST_DECODE: begin
          if (instr_vld_i && rom_illegal) begin
            illegal_d = 1'b1;
          end else if (instr_vld_i) begin
            ctrl_d    = rom_ctrl;
            alu_sel_d = rom_alu_sel;
            vld_d     = 1'b1;
            case (rom_kind)
              KindLdm: state_d = CU_ST_LDM_IMM;
              KindRet: begin cnt_d = CntW'(RET_BUBBLES); state_d = CU_ST_FLUSH; end
              KindRti: begin cnt_d = CntW'(RTI_BUBBLES); state_d = CU_ST_FLUSH; end
              KindInt: begin
                cnt_d   = CntW'(INT_CYCLES - 1);
                state_d = (INT_CYCLES > 1) ? CU_ST_INT_SEQ : CU_ST_DECODE;
              end
              default: state_d = CU_ST_DECODE;
            endcase
          end
        end
        CU_ST_LDM_IMM: begin
          ctrl_d    = CTRL_LDM_IMM;
          alu_sel_d = ALU_SEL_W'(ALU_MOV);
          imm_d     = 1'b1;
          vld_d     = 1'b1;
          state_d   = CU_ST_DECODE;
        end
        CU_ST_FLUSH: begin
          pc_hold_d = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
          // Leave on the cycle the counter reaches zero so the bubble count is exact.
          if (cnt_q <= CntW'(1)) state_d = CU_ST_DECODE;
        end
        CU_ST_INT_SEQ: begin
          ctrl_d    = CTRL_PUSH;
          pc_hold_d = 1'b1;
          vld_d     = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
          if (cnt_q <= CntW'(1)) state_d = CU_ST_DECODE;
        end
        default: state_d = CU_ST_DECODE;
      endcase
    end
  end

`ifdef CU_PERF_CNT_EN
  logic [15:0] bubble_cnt_q, instr_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CU_ST_DECODE;
      cnt_q     <= '0;
      ctrl_q    <= CTRL_NOP;
      alu_sel_q <= ALU_SEL_W'(ALU_NOP);
      imm_q     <= 1'b0;
      pc_hold_q <= 1'b0;
      vld_q     <= 1'b0;
      illegal_q <= 1'b0;
`ifdef CU_PERF_CNT_EN
      bubble_cnt_q <= '0;
      instr_cnt_q  <= '0;
`endif
    end else if (!stall_i) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      alu_sel_q <= alu_sel_d;
      imm_q     <= imm_d;
      pc_hold_q <= pc_hold_d;
      vld_q     <= vld_d;
      illegal_q <= illegal_d;
`ifdef CU_PERF_CNT_EN
      if (pc_hold_d && bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
      if (vld_d && instr_cnt_q != 16'hFFFF) instr_cnt_q <= instr_cnt_q + 16'd1;
`endif
    end
  end

  assign ctrl_o     = ctrl_q;
  assign alu_sel_o  = alu_sel_q;
  assign imm_o      = imm_q;
  assign pc_hold_o  = pc_hold_q;
  assign ctrl_vld_o = vld_q;
  assign busy_o     = (state_q != CU_ST_DECODE);
  assign illegal_o  = illegal_q;
`ifdef CU_PERF_CNT_EN
  assign bubble_cnt_o = bubble_cnt_q;
  assign instr_cnt_o  = instr_cnt_q;
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed self-checking bench for seq_control_unit (default parameters).
module tb_seq_control_unit;
  import seq_control_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_vld_i = 1'b0;
  logic [4:0] opcode_i = '0;
  logic       stall_i = 1'b0;
  logic       kill_i = 1'b0;
  logic [9:0] ctrl_o;
  logic [3:0] alu_sel_o;
  logic       imm_o, pc_hold_o, ctrl_vld_o, busy_o, illegal_o;
`ifdef CU_PERF_CNT_EN
  logic [15:0] bubble_cnt_o, instr_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_control_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_vld_i (instr_vld_i),
    .opcode_i    (opcode_i),
    .stall_i     (stall_i),
    .kill_i      (kill_i),
    .ctrl_o      (ctrl_o),
    .alu_sel_o   (alu_sel_o),
    .imm_o       (imm_o),
    .pc_hold_o   (pc_hold_o),
    .ctrl_vld_o  (ctrl_vld_o),
    .busy_o      (busy_o),
    .illegal_o   (illegal_o)
`ifdef CU_PERF_CNT_EN
    ,
    .bubble_cnt_o (bubble_cnt_o),
    .instr_cnt_o  (instr_cnt_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [4:0] op);
    instr_vld_i = vld;
    opcode_i    = op;
  endtask

  task automatic check_out(input string tag, input logic [9:0] ctrl, input logic [3:0] alu,
                           input logic imm, input logic hold, input logic vld, input logic busy,
                           input logic ill);
    check_eq({tag, ".ctrl"}, 32'(ctrl_o), 32'(ctrl));
    check_eq({tag, ".alu"}, 32'(alu_sel_o), 32'(alu));
    check_eq({tag, ".imm"}, 32'(imm_o), 32'(imm));
    check_eq({tag, ".hold"}, 32'(pc_hold_o), 32'(hold));
    check_eq({tag, ".vld"}, 32'(ctrl_vld_o), 32'(vld));
    check_eq({tag, ".busy"}, 32'(busy_o), 32'(busy));
    check_eq({tag, ".ill"}, 32'(illegal_o), 32'(ill));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    check_out("reset", 10'h000, 4'd0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;

    // ADD decodes to ALU bundle one cycle later
    drive(1, 5'(OP_ADD));
    step();
    check_out("add", 10'b0000001000, 4'd1, 0, 0, 1, 0, 0);
`ifdef CU_PERF_CNT_EN
    check_eq("perf.instr1", 32'(instr_cnt_o), 32'd1);
`endif

    // LDM then immediate word; the immediate must not be decoded as PUSH
    drive(1, 5'(OP_LDM));
    step();
    check_out("ldm1", 10'b0000000000, 4'd0, 0, 0, 1, 1, 0);
    drive(1, 5'h14 & 5'(OP_PUSH) | 5'(OP_PUSH));
    step();
    check_out("ldm2", 10'b0000011000, 4'd8, 1, 0, 1, 0, 0);
    drive(0, 5'd0);
    step();
    check_out("ldm3", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);

    // RET: branch bundle then exactly two bubbles
    drive(1, 5'(OP_RET));
    step();
    check_out("ret0", 10'b0000000100, 4'd0, 0, 0, 1, 1, 0);
    drive(0, 5'd0);
    step();
    check_out("ret_b1", 10'b0000000000, 4'd0, 0, 1, 0, 1, 0);
    step();
    check_out("ret_b2", 10'b0000000000, 4'd0, 0, 1, 0, 0, 0);
    step();
    check_out("ret_end", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);
`ifdef CU_PERF_CNT_EN
    check_eq("perf.bubble_ret", 32'(bubble_cnt_o), 32'd2);
`endif

    // RTI: three bubbles
    drive(1, 5'(OP_RTI));
    step();
    check_out("rti0", 10'b0000000100, 4'd0, 0, 0, 1, 1, 0);
    drive(0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rti_bubble", 32'(pc_hold_o), 32'd1);
    end
    step();
    check_out("rti_end", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);

    // RTI with a 4-cycle stall after the first bubble
    drive(1, 5'(OP_RTI));
    step();
    drive(0, 5'd0);
    step();
    check_out("stl_b1", 10'b0000000000, 4'd0, 0, 1, 0, 1, 0);
    stall_i = 1'b1;
    kill_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("stl_frz", 10'b0000000000, 4'd0, 0, 1, 0, 1, 0);
    end
    stall_i = 1'b0;
    kill_i  = 1'b0;
    step();
    check_eq("stl_b2", 32'(pc_hold_o), 32'd1);
    step();
    check_eq("stl_b3", 32'(pc_hold_o), 32'd1);
    step();
    check_out("stl_end", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);
`ifdef CU_PERF_CNT_EN
    check_eq("perf.bubble_all", 32'(bubble_cnt_o), 32'd8);
`endif

    // LDM killed: immediate dropped, next word decoded normally
    drive(1, 5'(OP_LDM));
    step();
    check_eq("kill_busy", 32'(busy_o), 32'd1);
    kill_i = 1'b1;
    drive(1, 5'(OP_PUSH));
    step();
    check_out("kill", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);
    kill_i = 1'b0;
    drive(1, 5'(OP_ADD));
    step();
    check_out("post_kill", 10'b0000001000, 4'd1, 0, 0, 1, 0, 0);

    // INT: INT bundle then one push cycle
    drive(1, 5'(OP_INT));
    step();
    check_out("int0", 10'b0001000100, 4'd0, 0, 0, 1, 1, 0);
    drive(0, 5'd0);
    step();
    check_out("int1", 10'b0001000000, 4'd0, 0, 1, 1, 0, 0);
    step();
    check_out("int_end", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of INT_SEQ
    drive(1, 5'(OP_INT));
    step();
    drive(0, 5'd0);
    check_eq("int_pre_rst", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    check_out("post_rst", 10'b0000000000, 4'd0, 0, 0, 0, 0, 0);
`ifdef CU_PERF_CNT_EN
    check_eq("perf.rst_b", 32'(bubble_cnt_o), 32'd0);
    check_eq("perf.rst_i", 32'(instr_cnt_o), 32'd0);
`endif

    // Undefined opcode pulses illegal_o for one cycle
    drive(1, 5'h1F);
    step();
    check_out("illegal", 10'b0000000000, 4'd0, 0, 0, 0, 0, 1);
    drive(0, 5'd0);
    step();
    check_eq("illegal_clr", 32'(illegal_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
